conv_row_scheduler: RTL and testbench

Sequences input-feature-map row addresses for the 1-D convolution engine. For each output window it issues the K kernel rows (base+0 … base+K-1), then advances base by Stride until the window no longer fits in the IF height. Rows go to the downstream row fetcher over a valid/ready handshake. The block also reports window/frame boundaries, completion and configuration errors to the top-level controller.

---
 rtl/conv_row_scheduler_pkg.sv | 15 +
 rtl/conv_row_window_counter.sv | 74 +++++++
 rtl/conv_row_scheduler.sv | 165 ++++++++++++++++
 tb/tb_conv_row_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_row_scheduler_pkg.sv
// Shared types and default widths for the convolution row scheduler.
package conv_row_scheduler_pkg;

   localparam int unsigned DEF_BITWIDTH_ROW     = 4;
   localparam int unsigned DEF_BITWIDTH_IF_ROWS = 10;
   localparam int unsigned DEF_BITWIDTH_STRIDE  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/conv_row_window_counter.sv
// Base/offset walker for one frame; all row outputs are registered so the
// flags are ready in the same cycle as the row address they describe.
module conv_row_window_counter
   import conv_row_scheduler_pkg::*;
#(
   parameter int unsigned BITWIDTH_ROW     = DEF_BITWIDTH_ROW,
   parameter int unsigned BITWIDTH_IF_ROWS = DEF_BITWIDTH_IF_ROWS,
   parameter int unsigned BITWIDTH_STRIDE  = DEF_BITWIDTH_STRIDE
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        step,
   input  logic [BITWIDTH_ROW-1:0]     kernel_rows,
   input  logic [BITWIDTH_STRIDE-1:0]  stride,
   input  logic [BITWIDTH_IF_ROWS-1:0] if_rows,
   output logic [BITWIDTH_IF_ROWS-1:0] row_addr,
   output logic [BITWIDTH_ROW-1:0]     offset,
   output logic                        window_last,
   output logic                        frame_last
);

   localparam int unsigned W_IF   = BITWIDTH_IF_ROWS;
   localparam int unsigned W_ROW  = BITWIDTH_ROW;
   localparam int unsigned FIT_W  = BITWIDTH_IF_ROWS + 1;
   localparam int unsigned ROW_W1 = BITWIDTH_ROW + 1;

   logic [W_IF-1:0]  base;
   logic [W_IF-1:0]  base_d;
   logic [W_IF-1:0]  addr_d;
   logic [W_ROW-1:0] offset_d;
   logic             last_d;
   logic             frame_d;

   // Next position, then the flags that describe it (one bit wider so the fit test never wraps).
   always_comb begin
      base_d   = base;
      offset_d = offset;
      if (clear) begin
         base_d   = '0;
         offset_d = '0;
      end else if (step) begin
         if (!window_last) begin
            offset_d = offset + W_ROW'(1);
         end else begin
            offset_d = '0;
            if (!frame_last) begin
               base_d = base + W_IF'(stride);
            end
         end
      end
      addr_d  = base_d + W_IF'(offset_d);
      last_d  = (ROW_W1'(offset_d) + ROW_W1'(1)) == ROW_W1'(kernel_rows);
      frame_d = last_d &&
                ((FIT_W'(base_d) + FIT_W'(stride) + FIT_W'(kernel_rows)) > FIT_W'(if_rows));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base        <= '0;
         offset      <= '0;
         row_addr    <= '0;
         window_last <= 1'b0;
         frame_last  <= 1'b0;
      end else begin
         base        <= base_d;
         offset      <= offset_d;
         row_addr    <= addr_d;
         window_last <= last_d;
         frame_last  <= frame_d;
      end
   end

endmodule

// File: rtl/conv_row_scheduler.sv
// Issues K kernel rows per output window, sliding by Stride until the window
// no longer fits in the IF height; reports window/frame ends, done and errors.
module conv_row_scheduler
   import conv_row_scheduler_pkg::*;
#(
   parameter int unsigned BITWIDTH_ROW     = DEF_BITWIDTH_ROW,
   parameter int unsigned BITWIDTH_IF_ROWS = DEF_BITWIDTH_IF_ROWS,
   parameter int unsigned BITWIDTH_STRIDE  = DEF_BITWIDTH_STRIDE
) (
   input  logic                        CONV_ROW_SCHEDULER_clk,
   input  logic                        CONV_ROW_SCHEDULER_Clr,
   input  logic                        CONV_ROW_SCHEDULER_Start,
   input  logic [BITWIDTH_STRIDE-1:0]  CONV_ROW_SCHEDULER_Stride,
   input  logic [BITWIDTH_ROW-1:0]     CONV_ROW_SCHEDULER_Kernel_Rows,
   input  logic [BITWIDTH_IF_ROWS-1:0] CONV_ROW_SCHEDULER_IF_Rows,
   input  logic                        CONV_ROW_SCHEDULER_Row_Ready,
   output logic                        CONV_ROW_SCHEDULER_Row_Valid,
   output logic [BITWIDTH_IF_ROWS-1:0] CONV_ROW_SCHEDULER_Row_Addr,
   output logic [BITWIDTH_ROW-1:0]     CONV_ROW_SCHEDULER_Row_Offset,
   output logic                        CONV_ROW_SCHEDULER_Window_Last,
   output logic                        CONV_ROW_SCHEDULER_Frame_Last,
   output logic [BITWIDTH_IF_ROWS-1:0] CONV_ROW_SCHEDULER_Window_Count,
   output logic                        CONV_ROW_SCHEDULER_Busy,
   output logic                        CONV_ROW_SCHEDULER_Done,
   output logic                        CONV_ROW_SCHEDULER_Err
);

   localparam int unsigned W_IF  = BITWIDTH_IF_ROWS;
   localparam int unsigned W_ROW = BITWIDTH_ROW;
   localparam int unsigned W_S   = BITWIDTH_STRIDE;
   localparam int unsigned FIT_W = BITWIDTH_IF_ROWS + 1;

   state_t           state_q, state_d;
   logic [W_ROW-1:0] k_q, k_d;
   logic [W_S-1:0]   s_q, s_d;
   logic [W_IF-1:0]  h_q, h_d;
   logic [W_IF-1:0]  cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             start_clr;
   logic             step;
   logic             cfg_err;
   logic             handshake;
   logic             window_last;
   logic             frame_last;

   assign handshake = valid_q & CONV_ROW_SCHEDULER_Row_Ready;
   assign cfg_err   = (k_q == '0) || (s_q == '0) || (FIT_W'(k_q) > FIT_W'(h_q));

   always_ff @(posedge CONV_ROW_SCHEDULER_clk) begin
      if (!CONV_ROW_SCHEDULER_Clr) begin
         state_q <= IDLE;
         k_q     <= '0;
         s_q     <= '0;
         h_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         s_q     <= s_d;
         h_q     <= h_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next state plus the registered status outputs that accompany it.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      s_d       = s_q;
      h_d       = h_q;
      cnt_d     = cnt_q;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      start_clr = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            if (CONV_ROW_SCHEDULER_Start) begin
               k_d       = CONV_ROW_SCHEDULER_Kernel_Rows;
               s_d       = CONV_ROW_SCHEDULER_Stride;
               h_d       = CONV_ROW_SCHEDULER_IF_Rows;
               err_d     = 1'b0;
               cnt_d     = '0;
               start_clr = 1'b1;
               busy_d    = 1'b1;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            if (cfg_err) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (handshake) begin
               step = 1'b1;
               if (window_last) begin
                  cnt_d = cnt_q + W_IF'(1);
                  if (frame_last) begin
                     valid_d = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Clearing again in CHECK re-derives the flags from the freshly latched config.
   conv_row_window_counter #(
      .BITWIDTH_ROW     (BITWIDTH_ROW),
      .BITWIDTH_IF_ROWS (BITWIDTH_IF_ROWS),
      .BITWIDTH_STRIDE  (BITWIDTH_STRIDE)
   ) u_window_counter (
      .clk         (CONV_ROW_SCHEDULER_clk),
      .rst_n       (CONV_ROW_SCHEDULER_Clr),
      .clear       (start_clr | (state_q == CHECK)),
      .step        (step),
      .kernel_rows (k_q),
      .stride      (s_q),
      .if_rows     (h_q),
      .row_addr    (CONV_ROW_SCHEDULER_Row_Addr),
      .offset      (CONV_ROW_SCHEDULER_Row_Offset),
      .window_last (window_last),
      .frame_last  (frame_last)
   );

   assign CONV_ROW_SCHEDULER_Window_Last  = window_last;
   assign CONV_ROW_SCHEDULER_Frame_Last   = frame_last;
   assign CONV_ROW_SCHEDULER_Row_Valid    = valid_q;
   assign CONV_ROW_SCHEDULER_Window_Count = cnt_q;
   assign CONV_ROW_SCHEDULER_Busy         = busy_q;
   assign CONV_ROW_SCHEDULER_Done         = done_q;
   assign CONV_ROW_SCHEDULER_Err          = err_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed frame vectors for conv_row_scheduler with an independent row model.
module tb_conv_row_scheduler;

   logic       clk = 1'b0;
   logic       clr;
   logic       start;
   logic [3:0] stride;
   logic [3:0] kernel_rows;
   logic [9:0] if_rows;
   logic       row_ready;
   logic       row_valid;
   logic [9:0] row_addr;
   logic [3:0] row_offset;
   logic       window_last;
   logic       frame_last;
   logic [9:0] window_count;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_row_scheduler dut (
      .CONV_ROW_SCHEDULER_clk          (clk),
      .CONV_ROW_SCHEDULER_Clr          (clr),
      .CONV_ROW_SCHEDULER_Start        (start),
      .CONV_ROW_SCHEDULER_Stride       (stride),
      .CONV_ROW_SCHEDULER_Kernel_Rows  (kernel_rows),
      .CONV_ROW_SCHEDULER_IF_Rows      (if_rows),
      .CONV_ROW_SCHEDULER_Row_Ready    (row_ready),
      .CONV_ROW_SCHEDULER_Row_Valid    (row_valid),
      .CONV_ROW_SCHEDULER_Row_Addr     (row_addr),
      .CONV_ROW_SCHEDULER_Row_Offset   (row_offset),
      .CONV_ROW_SCHEDULER_Window_Last  (window_last),
      .CONV_ROW_SCHEDULER_Frame_Last   (frame_last),
      .CONV_ROW_SCHEDULER_Window_Count (window_count),
      .CONV_ROW_SCHEDULER_Busy         (busy),
      .CONV_ROW_SCHEDULER_Done         (done),
      .CONV_ROW_SCHEDULER_Err          (err)
   );

   typedef struct {
      int h;
      int k;
      int s;
      bit toggle;
      bit poke;
      bit exp_err;
      int exp_windows;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(row_valid), 0);
      chk({tag, "_addr"}, 32'(row_addr), 0);
      chk({tag, "_offset"}, 32'(row_offset), 0);
      chk({tag, "_wlast"}, 32'(window_last), 0);
      chk({tag, "_flast"}, 32'(frame_last), 0);
      chk({tag, "_wcount"}, 32'(window_count), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int q_addr[$];
      int q_off[$];
      int q_wl[$];
      int q_fl[$];
      int done_cyc    = -1;
      int first_valid = -1;
      int last_hs     = -1;
      bit phase       = 1'b1;
      bit prev_stall  = 1'b0;
      int prev_addr   = 0;
      bit rdy;
      int n_exp;
      string tag;
      tag = $sformatf("v%0d", idx);

      @(posedge clk); #1;
      start       = 1'b1;
      if_rows     = 10'(v.h);
      kernel_rows = 4'(v.k);
      stride      = 4'(v.s);
      row_ready   = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      // Config changes after acceptance must be ignored.
      if_rows     = 10'd2;
      kernel_rows = 4'd9;
      stride      = 4'd0;
      chk({tag, "_check_busy"}, 32'(busy), 1);
      chk({tag, "_check_valid"}, 32'(row_valid), 0);
      chk({tag, "_err_cleared"}, 32'(err), 0);
      chk({tag, "_wcount_cleared"}, 32'(window_count), 0);

      for (int c = 1; c < 5000; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            done_cyc = c;
            break;
         end
         if (row_valid) begin
            if (first_valid < 0) first_valid = c;
            if (prev_stall) chk({tag, "_stall_hold"}, 32'(row_addr), 32'(prev_addr));
            rdy = v.toggle ? phase : 1'b1;
            phase = ~phase;
            row_ready = rdy;
            if (rdy) begin
               q_addr.push_back(int'(row_addr));
               q_off.push_back(int'(row_offset));
               q_wl.push_back(int'(window_last));
               q_fl.push_back(int'(frame_last));
               last_hs = c;
            end
            prev_stall = !rdy;
            prev_addr  = int'(row_addr);
            if (v.poke && c == 3) begin
               start       = 1'b1;
               if_rows     = 10'd3;
               kernel_rows = 4'd1;
               stride      = 4'd1;
            end
         end else begin
            row_ready = 1'b1;
         end
      end

      chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 1);
      chk({tag, "_done_busy"}, 32'(busy), 0);
      chk({tag, "_done_valid"}, 32'(row_valid), 0);
      chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
      chk({tag, "_wcount"}, 32'(window_count), 32'(v.exp_windows));
      if (v.exp_err) begin
         chk({tag, "_err_done_cyc"}, 32'(done_cyc), 1);
         chk({tag, "_err_no_valid"}, 32'(first_valid), 32'(-1));
      end else begin
         chk({tag, "_first_valid_cyc"}, 32'(first_valid), 1);
         chk({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
      end

      if (v.poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_done_pulse_end"}, 32'(done), 0);
      chk({tag, "_idle_busy"}, 32'(busy), 0);
      chk({tag, "_err_hold"}, 32'(err), 32'(v.exp_err));

      n_exp = v.exp_windows * v.k;
      chk({tag, "_row_count"}, 32'(q_addr.size()), 32'(n_exp));
      for (int i = 0; i < q_addr.size() && i < n_exp; i++) begin
         int w;
         int o;
         w = i / v.k;
         o = i % v.k;
         chk($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(w * v.s + o));
         chk($sformatf("%s_off%0d", tag, i), 32'(q_off[i]), 32'(o));
         chk($sformatf("%s_wl%0d", tag, i), 32'(q_wl[i]), 32'(o == v.k - 1));
         chk($sformatf("%s_fl%0d", tag, i), 32'(q_fl[i]),
             32'((o == v.k - 1) && (w == v.exp_windows - 1)));
      end
   endtask

   initial begin
      //           h     k   s  tog poke err windows
      vecs[0] = '{5,    3,  1, 0,  0,   0,  3};
      vecs[1] = '{3,    4,  1, 0,  0,   1,  0};
      vecs[2] = '{8,    3,  2, 1,  0,   0,  3};
      vecs[3] = '{5,    0,  1, 0,  0,   1,  0};
      vecs[4] = '{5,    3,  0, 0,  0,   1,  0};
      vecs[5] = '{1023, 15, 15, 0, 0,   0,  68};
      vecs[6] = '{6,    2,  2, 1,  1,   0,  3};
      vecs[7] = '{4,    4,  3, 0,  0,   0,  1};
      vecs[8] = '{1,    1,  1, 0,  0,   0,  1};
      vecs[9] = '{7,    1,  3, 0,  1,   0,  3};

      clr         = 1'b0;
      start       = 1'b0;
      stride      = '0;
      kernel_rows = '0;
      if_rows     = '0;
      row_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      clr = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset while a row is being offered mid-window.
      @(posedge clk); #1;
      start       = 1'b1;
      if_rows     = 10'd5;
      kernel_rows = 4'd3;
      stride      = 4'd1;
      row_ready   = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      row_ready = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid_before", 32'(row_valid), 1);
      chk("midrst_addr_before", 32'(row_addr), 1);
      clr = 1'b0;
      @(posedge clk); #1;
      chk_all_zero("midrst");
      @(posedge clk); #1;
      chk("midrst_stay_idle", 32'(row_valid), 0);
      clr = 1'b1;
      run_vec(vecs[0], 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
